// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: valid/ready handshake, two-entry skid buffer, flush, jump-target select.
// Optional back-pressure counter enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  regwrite_in,
  input  logic                  MemtoReg_in,
  input  logic                  branch_in,
  input  logic                  MemRead_in,
  input  logic                  MemWrite_in,
  input  logic                  zero_in,
  input  logic                  jump_in,
  input  logic [DATA_W-1:0]     next_instr_in,
  input  logic [DATA_W-1:0]     jump_addr_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     read_data2_in,
  input  logic [REG_ADDR_W-1:0] write_reg_addr_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  regwrite_out,
  output logic                  MemtoReg_out,
  output logic                  branch_out,
  output logic                  MemRead_out,
  output logic                  MemWrite_out,
  output logic                  zero_out,
  output logic [DATA_W-1:0]     next_instr_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [DATA_W-1:0]     read_data2_out,
  output logic [REG_ADDR_W-1:0] write_reg_addr_out,
  output logic [31:0]           stall_cnt_out
);

  typedef struct packed {
    logic                  regwrite;
    logic                  memtoreg;
    logic                  branch;
    logic                  memread;
    logic                  memwrite;
    logic                  zero;
    logic [DATA_W-1:0]     next_instr;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     read_data2;
    logic [REG_ADDR_W-1:0] wr_addr;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t state, state_d;
  entry_t main_q, skid_q, in_e;
  logic   accept, drain, load_main, load_skid, skid_to_main;

  // Jump target is resolved here so only one address travels downstream.
  assign in_e = '{
    regwrite:   regwrite_in,
    memtoreg:   MemtoReg_in,
    branch:     branch_in,
    memread:    MemRead_in,
    memwrite:   MemWrite_in,
    zero:       zero_in,
    next_instr: jump_in ? jump_addr_in : next_instr_in,
    alu_result: alu_result_in,
    read_data2: read_data2_in,
    wr_addr:    write_reg_addr_in
  };

  assign in_ready  = (state != SKID);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d      = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) begin
          state_d   = FULL;
          load_main = 1'b1;
        end
        FULL: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = SKID;
            load_skid = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        SKID: if (drain) begin
          state_d      = FULL;
          skid_to_main = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)         main_q <= in_e;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= in_e;
    end
  end

  assign regwrite_out       = main_q.regwrite & out_valid;
  assign MemtoReg_out       = main_q.memtoreg & out_valid;
  assign branch_out         = main_q.branch   & out_valid;
  assign MemRead_out        = main_q.memread  & out_valid;
  assign MemWrite_out       = main_q.memwrite & out_valid;
  assign zero_out           = main_q.zero     & out_valid;
  assign next_instr_out     = main_q.next_instr;
  assign alu_result_out     = main_q.alu_result;
  assign read_data2_out     = main_q.read_data2;
  assign write_reg_addr_out = main_q.wr_addr;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
  // Saturating; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
  assign stall_cnt_out = stall_cnt;
`else
  assign stall_cnt_out = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Randomised scoreboard bench for ex_mem_stage_reg: queue-based model of the stage, monitor on negedge.
module tb_ex_mem_stage_reg;
  logic        clk = 1'b0, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic        regwrite_in, MemtoReg_in, branch_in, MemRead_in, MemWrite_in, zero_in, jump_in;
  logic [31:0] next_instr_in, jump_addr_in, alu_result_in, read_data2_in;
  logic [4:0]  write_reg_addr_in;
  logic        regwrite_out, MemtoReg_out, branch_out, MemRead_out, MemWrite_out, zero_out;
  logic [31:0] next_instr_out, alu_result_out, read_data2_out, stall_cnt_out;
  logic [4:0]  write_reg_addr_out;

  ex_mem_stage_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .regwrite_in(regwrite_in), .MemtoReg_in(MemtoReg_in), .branch_in(branch_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .zero_in(zero_in), .jump_in(jump_in),
    .next_instr_in(next_instr_in), .jump_addr_in(jump_addr_in), .alu_result_in(alu_result_in),
    .read_data2_in(read_data2_in), .write_reg_addr_in(write_reg_addr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .regwrite_out(regwrite_out), .MemtoReg_out(MemtoReg_out), .branch_out(branch_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .zero_out(zero_out),
    .next_instr_out(next_instr_out), .alu_result_out(alu_result_out),
    .read_data2_out(read_data2_out), .write_reg_addr_out(write_reg_addr_out),
    .stall_cnt_out(stall_cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  ctl;   // {regwrite, MemtoReg, branch, MemRead, MemWrite, zero}
    logic [31:0] ni, alu, rd2;
    logic [4:0]  wa;
  } exp_t;

  exp_t        q[$];          // entries the stage holds, head first
  int          checks = 0, errors = 0;
  bit          start = 0;
  bit          drive_ready, drive_outv;
  logic [31:0] model_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_rand(input int cyc);
    regwrite_in = 1'($urandom); MemtoReg_in = 1'($urandom); branch_in = 1'($urandom);
    MemRead_in = 1'($urandom); MemWrite_in = 1'($urandom); zero_in = 1'($urandom);
    jump_in = 1'($urandom);
    next_instr_in = $urandom; jump_addr_in = $urandom; alu_result_in = $urandom;
    read_data2_in = $urandom; write_reg_addr_in = 5'($urandom);
    if (cyc < 3) begin            // fill to SKID with backpressure, third offer refused
      in_valid = 1; out_ready = 0; flush = 0;
    end else if (cyc == 3) begin  // flush from SKID with a competing input
      in_valid = 1; out_ready = 0; flush = 1;
    end else if (cyc < 8) begin   // streaming
      in_valid = 1; out_ready = 1; flush = 0;
    end else if (cyc < 18) begin  // long stall, then release
      in_valid = (cyc < 10); out_ready = (cyc >= 16); flush = 0;
    end else begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 4);
    end
  endtask

  // Monitor: compare what the DUT presents against the head of the model.
  always @(negedge clk) if (start) begin
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("stall_cnt", stall_cnt_out, model_stall);
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL head: DUT valid but model empty at %0t", $time);
      end else begin
        chk("ctl", 32'({regwrite_out, MemtoReg_out, branch_out, MemRead_out, MemWrite_out, zero_out}), 32'(q[0].ctl));
        chk("next_instr", next_instr_out, q[0].ni);
        chk("alu_result", alu_result_out, q[0].alu);
        chk("read_data2", read_data2_out, q[0].rd2);
        chk("wr_addr", 32'(write_reg_addr_out), 32'(q[0].wa));
      end
    end else begin
      chk("ctl_bubble", 32'({regwrite_out, MemtoReg_out, branch_out, MemRead_out, MemWrite_out, zero_out}), 32'd0);
    end
    if (q.size() > 0 && out_ready && !flush) void'(q.pop_front());
  end

  initial begin
    exp_t e;
    reset = 1; flush = 0; in_valid = 1; out_ready = 0;
    {regwrite_in, MemtoReg_in, branch_in, MemRead_in, MemWrite_in, zero_in, jump_in} = '1;
    next_instr_in = '1; jump_addr_in = '1; alu_result_in = '1; read_data2_in = '1;
    write_reg_addr_in = '1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ctl", 32'({regwrite_out, MemtoReg_out, branch_out, MemRead_out, MemWrite_out, zero_out}), 32'd0);
    chk("rst_next_instr", next_instr_out, 32'd0);
    chk("rst_alu", alu_result_out, 32'd0);
    chk("rst_rd2", read_data2_out, 32'd0);
    chk("rst_wa", 32'(write_reg_addr_out), 32'd0);
    chk("rst_stall", stall_cnt_out, 32'd0);
    #10 reset = 0;        // t=22; the all-ones entry is taken on the edge at t=25
    drive_ready = 1; drive_outv = 0; start = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      // Apply this edge's effect to the model using the inputs held during the cycle.
`ifdef EX_MEM_STALL_CNT_EN
      if (drive_outv && !out_ready && model_stall != 32'hFFFF_FFFF) model_stall++;
`endif
      if (flush) q.delete();
      else if (in_valid && drive_ready) begin
        e.ctl = {regwrite_in, MemtoReg_in, branch_in, MemRead_in, MemWrite_in, zero_in};
        e.ni  = jump_in ? jump_addr_in : next_instr_in;
        e.alu = alu_result_in; e.rd2 = read_data2_in; e.wa = write_reg_addr_in;
        q.push_back(e);
      end
      #2;
      drive_rand(cyc);
      drive_ready = (q.size() < 2);
      drive_outv  = (q.size() > 0);
    end
    @(negedge clk);
    start = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
